// File: rtl/enc_pkg.sv
// Shared constants and types for the sequential 8-to-3 encoder.
// Used by prio_sel8 and enc8to3_queue.
package enc_pkg;
    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] PTR_RST = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/prio_sel8.sv
// Combinational 8-way first-set search from a start index.
// dir=0 walks upward from start, dir=1 walks downward, both wrap.
module prio_sel8
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    input  logic              dir,
    output logic [CODE_W-1:0] idx,
    output logic [N_REQ-1:0]  mask,
    output logic              any
);
    logic [CODE_W-1:0] cand;

    // Walk the search order backwards so the nearest hit is written last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = dir ? start - CODE_W'(i) : start + CODE_W'(i);
            if (vec[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

    always_comb begin
        mask = '0;
        if (any)
            mask[idx] = 1'b1;
    end
endmodule

// File: rtl/enc8to3_queue.sv
// Sequential 8-to-3 encoder: queues request bits, emits one index per handshake.
// Define ENC8TO3_RR_EN for a round-robin selector instead of fixed priority.
module enc8to3_queue
    import enc_pkg::*;
#(
    parameter logic PRIORITY_HIGH = 1'b1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              En,
    input  logic [N_REQ-1:0]  Req,
    input  logic              Rdy,
    output logic [CODE_W-1:0] W,
    output logic              Valid,
    output logic [N_REQ-1:0]  Pending,
    output logic              Overflow
);
    state_t            state;
    state_t            state_nx;
    logic [CODE_W-1:0] sel_idx;
    logic [N_REQ-1:0]  sel_mask;
    logic              sel_any;
    logic [CODE_W-1:0] sel_start;
    logic              sel_dir;
    logic              load;
    logic [N_REQ-1:0]  load_mask;
    logic [N_REQ-1:0]  req_cap;

`ifdef ENC8TO3_RR_EN
    logic [CODE_W-1:0] ptr;

    assign sel_start = ptr + CODE_W'(1);
    assign sel_dir   = 1'b0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            ptr <= PTR_RST;
        else if (load)
            ptr <= sel_idx;
    end
`else
    assign sel_start = PRIORITY_HIGH ? CODE_W'(N_REQ - 1) : '0;
    assign sel_dir   = PRIORITY_HIGH;
`endif

    prio_sel8 u_sel (
        .vec   (Pending),
        .start (sel_start),
        .dir   (sel_dir),
        .idx   (sel_idx),
        .mask  (sel_mask),
        .any   (sel_any)
    );

    // A load happens from IDLE, or from HOLD on the handshake edge.
    assign load      = sel_any & ((state == IDLE) | Rdy);
    assign load_mask = load ? sel_mask : '0;
    assign req_cap   = En ? Req : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (sel_any) state_nx = HOLD;
            HOLD: if (Rdy && !sel_any) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Valid = (state == HOLD);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            W        <= '0;
            Pending  <= '0;
            Overflow <= 1'b0;
        end else begin
            if (load)
                W <= sel_idx;
            Pending <= (Pending & ~load_mask) | req_cap;
            if (|(req_cap & Pending & ~load_mask))
                Overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_enc8to3_queue.sv
// Self-checking bench: two instances (high/low priority) against a queue model.
// Build with ENC8TO3_RR_EN defined to check the round-robin selector.
module tb_enc8to3_queue;
    logic       Clock;
    logic       Resetn;
    logic       En;
    logic [7:0] Req;
    logic       Rdy;
    logic [2:0] w_h, w_l;
    logic       v_h, v_l;
    logic [7:0] p_h, p_l;
    logic       o_h, o_l;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] m_p   [2];
    logic       m_v   [2];
    logic [2:0] m_w   [2];
    logic       m_o   [2];
    logic [2:0] m_ptr [2];

    enc8to3_queue #(.PRIORITY_HIGH(1'b1)) dut_h (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Req(Req), .Rdy(Rdy),
        .W(w_h), .Valid(v_h), .Pending(p_h), .Overflow(o_h)
    );

    enc8to3_queue #(.PRIORITY_HIGH(1'b0)) dut_l (
        .Clock(Clock), .Resetn(Resetn), .En(En), .Req(Req), .Rdy(Rdy),
        .W(w_l), .Valid(v_l), .Pending(p_l), .Overflow(o_l)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [2:0] msel(logic [7:0] p, bit hi, logic [2:0] ptr);
        int j;
`ifdef ENC8TO3_RR_EN
        for (int k = 1; k <= 8; k++) begin
            j = (int'(ptr) + k) % 8;
            if (p[j]) return 3'(j);
        end
`else
        for (int k = 0; k < 8; k++) begin
            j = hi ? 7 - k : k;
            if (p[j]) return 3'(j);
        end
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_p[n] = 8'h00; m_v[n] = 1'b0; m_w[n] = 3'd0;
            m_o[n] = 1'b0;  m_ptr[n] = 3'd7;
        end
    endtask

    // One clock edge of the queue as described behaviourally.
    task automatic model_edge();
        logic [7:0] lm;
        logic [2:0] s;
        for (int n = 0; n < 2; n++) begin
            lm = 8'h00;
            if (m_p[n] != 8'h00 && (!m_v[n] || Rdy)) begin
                s = msel(m_p[n], n == 0, m_ptr[n]);
                lm = 8'h01 << s;
                m_w[n] = s; m_v[n] = 1'b1; m_ptr[n] = s;
            end else if (m_v[n] && Rdy) begin
                m_v[n] = 1'b0;
            end
            if (En && ((Req & m_p[n] & ~lm) != 8'h00)) m_o[n] = 1'b1;
            m_p[n] = (m_p[n] & ~lm) | (En ? Req : 8'h00);
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".W_h"}, 8'(w_h), 8'(m_w[0]));
        chk({tag, ".V_h"}, 8'(v_h), 8'(m_v[0]));
        chk({tag, ".P_h"}, p_h, m_p[0]);
        chk({tag, ".O_h"}, 8'(o_h), 8'(m_o[0]));
        chk({tag, ".W_l"}, 8'(w_l), 8'(m_w[1]));
        chk({tag, ".V_l"}, 8'(v_l), 8'(m_v[1]));
        chk({tag, ".P_l"}, p_l, m_p[1]);
        chk({tag, ".O_l"}, 8'(o_l), 8'(m_o[1]));
    endtask

    task automatic step(string tag);
        model_edge();
        @(posedge Clock);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(string tag);
        #2 Resetn = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        chk({tag, ".zero"}, {p_h[6:0], o_h}, 8'h00);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        logic [2:0] seq_h [4];
        logic [2:0] seq_l [4];
        seq_h = '{3'd7, 3'd5, 3'd2, 3'd0};
        seq_l = '{3'd0, 3'd2, 3'd5, 3'd7};
        Resetn = 1'b0; En = 1'b1; Req = 8'h00; Rdy = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;

        // Single request, then reset while the index is being presented.
        Req = 8'h10; step("cap10");
        Req = 8'h00; step("load10");
        chk("hold4.W", 8'(w_h), 8'd4);
        chk("hold4.V", 8'(v_h), 8'd1);
        async_reset("rst_hold");

        // Multi-hot drain with the consumer always ready.
        Rdy = 1'b1;
        Req = 8'hA5; step("mh_cap");
        Req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step("mh_drain");
`ifndef ENC8TO3_RR_EN
            chk("mh_seq_h", 8'(w_h), 8'(seq_h[i]));
            chk("mh_seq_l", 8'(w_l), 8'(seq_l[i]));
`endif
        end
        step("mh_idle");
        chk("mh_idle.V", 8'(v_h), 8'd0);

        // Backpressure holds the presented index.
        Rdy = 1'b0;
        Req = 8'h03; step("bp_cap");
        Req = 8'h00;
        for (int i = 0; i < 5; i++) step("bp_hold");
        Rdy = 1'b1;
        for (int i = 0; i < 3; i++) step("bp_drain");

        // Duplicate requests while pending, and a re-request of W.
        Rdy = 1'b0;
        Req = 8'h84; step("ov_cap");
        Req = 8'h00; step("ov_load");
        Req = 8'h04; step("ov_dup1");
        Req = 8'h04; step("ov_dup2");
        Req = 8'h00; step("ov_keep");
        async_reset("rst_ov");
        Req = 8'h40; step("wq_cap");
        Req = 8'h00; step("wq_load");
        Req = 8'h40; step("wq_rereq");
        chk("wq_noov", 8'(o_h), 8'd0);
        Req = 8'h00; Rdy = 1'b1;
        for (int i = 0; i < 3; i++) step("wq_drain");

        // Capture gating.
        En = 1'b0; Req = 8'hFF;
        for (int i = 0; i < 3; i++) step("en_off");
        chk("en_off.P", p_h, 8'h00);
        En = 1'b1; step("en_on");
        Req = 8'h00; step("en_valid");
        for (int i = 0; i < 9; i++) step("en_drain");

        // Two requests held every cycle.
        async_reset("rst_hold81");
        Req = 8'h81;
        for (int i = 0; i < 8; i++) step("hold81");
        Req = 8'h00;
        for (int i = 0; i < 4; i++) step("hold81_drain");

        // Randomised traffic with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            En  = ($urandom_range(0, 7) != 0);
            Req = 8'($urandom & $urandom & $urandom);
            Rdy = ($urandom_range(0, 3) != 0);
            if (i == 200) async_reset("rst_rand");
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/enc8to3_queue.md
Name: enc8to3_queue

Overview:
- Sequential 8-to-3 encoder; the inverse of the lab 3-to-8 decoder.
- Captures up to 8 one-hot/multi-hot request lines into a pending register.
- Emits one 3-bit index at a time over a Valid/Rdy handshake.
- Feeds decoder-driven select logic and event reporting in the lab datapath; no request is lost while it is waiting to be served.

Parameters:
- PRIORITY_HIGH, 1, fixed-priority direction. 1 = highest index served first; 0 = lowest index served first.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- En  input  1  request capture enable. 0 = Req ignored; draining continues.
- Req  input  8  request lines; any number of bits may be high in one cycle.
- Rdy  input  1  consumer ready; handshake occurs when Valid & Rdy are high at the same rising edge.
- W  output  3  encoded index of the request being presented.
- Valid  output  1  W holds a valid index.
- Pending  output  8  requests captured but not yet loaded into W.
- Overflow  output  1  sticky; a request hit a bit that was already pending.

Behaviour:
- Reset (Resetn=0, asynchronous): Pending=8'h00, W=3'b000, Valid=0, Overflow=0, state=IDLE. The reset takes effect immediately, even mid-handshake; the presented index and all pending requests are discarded.
- Capture: at each edge with En=1, Pending <= (Pending & ~load_mask) | Req.
  - load_mask is the one-hot bit moved into W this cycle, else 0.
  - With En=0, Req is not sampled.
- Overflow: set at an edge where En=1 and Req[i]=1 while Pending[i]=1 and bit i is not being loaded that cycle.
  - A request that matches only the index currently in W is not an overflow; it is queued.
  - Overflow is cleared only by reset.
- Selector (combinational, from registered Pending only; the same cycle's Req is excluded):
  - PRIORITY_HIGH=1: the highest set index is selected.
  - PRIORITY_HIGH=0: the lowest set index is selected.
- FSM states:
  - IDLE (Valid=0): if Pending != 0, load W <= selected index, clear that bit, Valid <= 1, go to HOLD. Otherwise stay.
  - HOLD (Valid=1): W and Valid are stable while Rdy=0.
    - On Valid & Rdy with Pending != 0: load the next index in the same edge (back-to-back, no bubble) and stay in HOLD.
    - On Valid & Rdy with Pending = 0: Valid <= 0, go to IDLE. W keeps its last value.
- Latency: Req high at edge k gives Valid=1 after edge k+1 when the FSM is in IDLE (2 cycles). Sustained throughput is 1 index per cycle while Rdy=1.
- Simultaneous events:
  - Requesting the bit being loaded this cycle re-sets it in Pending; it is served again later.
  - A handshake and new requests in the same edge are handled independently, as above.
- Req=8'h00 for all cycles: Valid stays 0 indefinitely.

Optional Feature:
- Macro: ENC8TO3_RR_EN.
- Defined: the selector is round-robin.
  - A 3-bit pointer holds the last loaded index; reset value is 3'b111.
  - The search starts at pointer+1 and goes upward, wrapping 7 to 0.
  - PRIORITY_HIGH is ignored.
- Undefined: fixed priority per PRIORITY_HIGH; no pointer register exists.

Decomposition:
- Shared package/include enc_pkg:
  - N_REQ=8, CODE_W=3.
  - State encodings IDLE=1'b0, HOLD=1'b1.
  - Pointer reset constant.
- One sub-module, prio_sel8: combinational.
  - Inputs: 8-bit vector, start pointer, direction.
  - Outputs: 3-bit index, one-hot mask, any flag.
  - Reused by both selector modes.

Test Plan:
- Reset mid-HOLD: Req=8'h10 served to Valid=1, W=3'd4; drop Resetn asynchronously -> Valid=0, W=0, Pending=0, Overflow=0 immediately.
- Multi-hot, fixed priority: PRIORITY_HIGH=1, Req=8'b1010_0101 for one cycle, Rdy=1 -> W sequence 7,5,2,0 on consecutive cycles, then Valid=0. With PRIORITY_HIGH=0 -> 0,2,5,7.
- Backpressure: Req=8'h03, Rdy=0 for 5 cycles -> W=1 stable, Valid=1, Pending=8'h01. Then Rdy=1 -> W=0 next cycle, then Valid=0.
- Overflow: Req=8'h04 twice while bit 2 is still pending (Rdy=0, W holding another index) -> Overflow=1, and it stays 1. Req on the index currently in W -> Overflow unchanged, and the index is re-served.
- En gating: En=0, Req=8'hFF -> Pending stays 0, Valid stays 0. En=1 -> Valid rises 2 cycles later.
- ENC8TO3_RR_EN: Req=8'h81 held every cycle, Rdy=1 -> W alternates 0,7,0,7 with no starvation, and Overflow=1.
